conv_window_sequencer: RTL and testbench

Controller that drives the 3x3 convolution line buffer for a multi-channel square feature map. On a start pulse it reads IMAGE_WIDTH x IMAGE_WIDTH pixels per channel from a 1-cycle-latency feature memory and streams them into the line buffer. It honours a downstream stall and counts the windows the line buffer emits. It reports per-channel and per-layer completion to the layer scheduler, and sits between the feature memory and the line buffer.

---
 rtl/conv_ctrl_pkg.sv | 30 +++
 rtl/conv_fetch_pipe.sv | 37 +++
 rtl/conv_window_sequencer.sv | 132 +++++++++++++
 tb/tb_conv_window_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and sizing helpers for the convolution window sequencer.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    NEXT_CH,
    DONE
  } state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Number of 3x3 windows a w x w map produces.
  function automatic int WIN_PER_CH(input int w);
    return (w - 2) * (w - 2);
  endfunction

  // Number of pixels in one w x w channel.
  function automatic int PIX_PER_CH(input int w);
    return w * w;
  endfunction

endpackage

// File: rtl/conv_fetch_pipe.sv
// Two-stage delay from memory read strobe to line-buffer pixel, with in-flight flag.
module conv_fetch_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rd_en,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_lb_valid,
  output logic [DATA_WIDTH-1:0] o_lb_data,
  output logic                  o_in_flight
);

  logic                  vld_p0_q;
  logic                  vld_p1_q;
  logic [DATA_WIDTH-1:0] data_p1_q;

  // p0: read issued last cycle, memory word present on i_rd_data
  // p1: captured word presented to the line buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
    end else begin
      vld_p0_q <= i_rd_en;
      vld_p1_q <= vld_p0_q;
      if (vld_p0_q) data_p1_q <= i_rd_data;
    end
  end

  assign o_lb_valid  = vld_p1_q;
  assign o_lb_data   = data_p1_q;
  // A pixel counts as in flight until it has been presented on the output.
  assign o_in_flight = vld_p0_q | vld_p1_q;

endmodule

// File: rtl/conv_window_sequencer.sv
// Sequences per-channel feature-memory reads into the 3x3 line buffer and
// tracks window completion for the layer scheduler.
module conv_window_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IMAGE_WIDTH = 4,
  parameter int NUM_CHANNEL = 3,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_start,
  input  logic [ADDR_WIDTH-1:0]                   i_base_addr,
  input  logic                                    i_stall,
  output logic                                    o_rd_en,
  output logic [ADDR_WIDTH-1:0]                   o_rd_addr,
  input  logic [DATA_WIDTH-1:0]                   i_rd_data,
  output logic                                    o_lb_valid,
  output logic [DATA_WIDTH-1:0]                   o_lb_data,
  input  logic                                    i_win_valid,
  output logic [clog2(NUM_CHANNEL):0]             o_channel,
  output logic [clog2(WIN_PER_CH(IMAGE_WIDTH)):0] o_win_count,
  output logic                                    o_busy,
  output logic                                    o_ch_done,
  output logic                                    o_done
);

  localparam int PIX  = PIX_PER_CH(IMAGE_WIDTH);
  localparam int WIN  = WIN_PER_CH(IMAGE_WIDTH);
  localparam int CH_W = clog2(NUM_CHANNEL) + 1;
  localparam int WC_W = clog2(WIN) + 1;
  localparam int PC_W = clog2(PIX) + 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [PC_W-1:0]       pix_q, pix_d;
  logic [WC_W-1:0]       win_q, win_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  drain_ok;
  logic                  in_flight;

  // Window counter stops at the per-channel total; extra windows are an error
  // upstream and must not wrap the count back into range.
  function automatic logic [WC_W-1:0] win_sat_inc(input logic [WC_W-1:0] cnt);
    if (cnt >= WC_W'(WIN)) return cnt;
    return cnt + WC_W'(1);
  endfunction

  // Next-state and counter updates for the channel sequencing FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    pix_d    = pix_q;
    win_d    = win_q;
    ch_d     = ch_q;
    drain_ok = 1'b0;
    if (i_win_valid && (state_q != IDLE)) win_d = win_sat_inc(win_q);
    case (state_q)
      IDLE: begin
        if (i_start) begin
          ptr_d   = i_base_addr;
          pix_d   = '0;
          win_d   = '0;
          ch_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!i_stall) begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
          pix_d = pix_q + PC_W'(1);
          if (pix_q == PC_W'(PIX - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The window arriving this cycle already counts toward completion.
        if (!in_flight && (win_d == WC_W'(WIN))) begin
          drain_ok = 1'b1;
          state_d  = (ch_q == CH_W'(NUM_CHANNEL - 1)) ? DONE : NEXT_CH;
        end
      end
      NEXT_CH: begin
        ch_d    = ch_q + CH_W'(1);
        pix_d   = '0;
        win_d   = '0;
        state_d = FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, read pointer and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      pix_q   <= '0;
      win_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pix_q   <= pix_d;
      win_q   <= win_d;
      ch_q    <= ch_d;
    end
  end

  // Read strobe must react to stall in the same cycle.
  assign o_rd_en     = (state_q == FETCH) && !i_stall;
  assign o_rd_addr   = ptr_q;
  assign o_channel   = ch_q;
  assign o_win_count = win_q;
  assign o_busy      = (state_q != IDLE);
  assign o_ch_done   = drain_ok;
  assign o_done      = (state_q == DONE);

  conv_fetch_pipe #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fetch_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_rd_en    (o_rd_en),
    .i_rd_data  (i_rd_data),
    .o_lb_valid (o_lb_valid),
    .o_lb_data  (o_lb_data),
    .o_in_flight(in_flight)
  );

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer (W=4, 3 channels).
module tb_conv_window_sequencer;

  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int NC  = 3;
  localparam int AW  = 16;
  localparam int PIX = IW * IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic          i_stall;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] i_rd_data;
  logic          o_lb_valid;
  logic [DW-1:0] o_lb_data;
  logic          i_win_valid;
  logic [2:0]    o_channel;
  logic [2:0]    o_win_count;
  logic          o_busy;
  logic          o_ch_done;
  logic          o_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lb_cnt;

  typedef struct { int cyc; logic [AW-1:0] addr; } rd_exp_t;
  typedef struct { int cyc; logic [DW-1:0] data; } px_exp_t;
  typedef struct { int cyc; int ch; } cd_exp_t;

  rd_exp_t rd_q[$];
  px_exp_t px_q[$];
  cd_exp_t cd_q[$];
  int      done_q[$];

  rd_exp_t mon_rd;
  px_exp_t mon_px;
  cd_exp_t mon_cd;
  int      mon_dn;

  conv_window_sequencer #(
    .DATA_WIDTH (DW),
    .IMAGE_WIDTH(IW),
    .NUM_CHANNEL(NC),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_base_addr(i_base_addr),
    .i_stall    (i_stall),
    .o_rd_en    (o_rd_en),
    .o_rd_addr  (o_rd_addr),
    .i_rd_data  (i_rd_data),
    .o_lb_valid (o_lb_valid),
    .o_lb_data  (o_lb_data),
    .i_win_valid(i_win_valid),
    .o_channel  (o_channel),
    .o_win_count(o_win_count),
    .o_busy     (o_busy),
    .o_ch_done  (o_ch_done),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {16'hC0DE, a};
  endfunction

  // Feature memory with one cycle of read latency.
  always @(posedge clk) i_rd_data <= o_rd_en ? mem_word(o_rd_addr) : '0;

  // Line-buffer stand-in: a window completes the cycle after pixel (r>=2,c>=2).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lb_cnt      <= 0;
      i_win_valid <= 1'b0;
    end else begin
      i_win_valid <= 1'b0;
      if (o_lb_valid) begin
        if (((lb_cnt / IW) >= 2) && ((lb_cnt % IW) >= 2)) i_win_valid <= 1'b1;
        lb_cnt <= (lb_cnt == PIX - 1) ? 0 : lb_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_rd_en) begin
        chk("rd_pending", 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) begin
          mon_rd = rd_q.pop_front();
          chk("rd_addr", 32'(o_rd_addr), 32'(mon_rd.addr));
          chk("rd_cycle", cyc, mon_rd.cyc);
        end
      end
      if (o_lb_valid) begin
        chk("px_pending", 32'(px_q.size() > 0), 32'd1);
        if (px_q.size() > 0) begin
          mon_px = px_q.pop_front();
          chk("px_data", o_lb_data, mon_px.data);
          chk("px_cycle", cyc, mon_px.cyc);
        end
      end
      if (o_ch_done) begin
        chk("chd_pending", 32'(cd_q.size() > 0), 32'd1);
        if (cd_q.size() > 0) begin
          mon_cd = cd_q.pop_front();
          chk("chd_cycle", cyc, mon_cd.cyc);
          chk("chd_channel", 32'(o_channel), mon_cd.ch);
        end
      end
      if (o_done) begin
        chk("done_pending", 32'(done_q.size() > 0), 32'd1);
        if (done_q.size() > 0) begin
          mon_dn = done_q.pop_front();
          chk("done_cycle", cyc, mon_dn);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic start(input logic [AW-1:0] base, output int s);
    tick();
    i_start     = 1'b1;
    i_base_addr = base;
    s           = cyc;
    tick();
    i_start = 1'b0;
  endtask

  // Push the full layer's expectations; stall only affects channel 0.
  task automatic expect_run(input logic [AW-1:0] base, input int s, input int stall_k,
                            input int stall_len, output int done_cyc);
    int f;
    int rc;
    int last;
    logic [AW-1:0] a;
    f    = s + 1;
    last = 0;
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < PIX; k++) begin
        rc = f + k + (((c == 0) && (k >= stall_k)) ? stall_len : 0);
        a  = base + AW'(c * PIX + k);
        rd_q.push_back('{rc, a});
        px_q.push_back('{rc + 2, mem_word(a)});
        last = rc;
      end
      cd_q.push_back('{last + 3, c});
      f = last + 5;
    end
    done_cyc = last + 4;
    done_q.push_back(done_cyc);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_rd_left"}, rd_q.size(), 0);
    chk({tag, "_px_left"}, px_q.size(), 0);
    chk({tag, "_chd_left"}, cd_q.size(), 0);
    chk({tag, "_done_left"}, done_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(o_rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(o_rd_addr), 0);
    chk({tag, "_lb_valid"}, 32'(o_lb_valid), 0);
    chk({tag, "_lb_data"}, o_lb_data, 0);
    chk({tag, "_channel"}, 32'(o_channel), 0);
    chk({tag, "_win_count"}, 32'(o_win_count), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_ch_done"}, 32'(o_ch_done), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d;
    rst         = 1'b1;
    i_start     = 1'b0;
    i_base_addr = '0;
    i_stall     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Three channels from 0x0100, no stall; start coincident with o_done.
    start(16'h0100, s);
    expect_run(16'h0100, s, PIX, 0, d);
    chk("a_busy_c1", 32'(o_busy), 1);
    goto(s + 20);
    chk("a_wincnt_c20", 32'(o_win_count), 4);
    chk("a_channel_c20", 32'(o_channel), 0);
    goto(s + 21);
    chk("a_channel_c21", 32'(o_channel), 1);
    chk("a_wincnt_c21", 32'(o_win_count), 0);
    goto(s + 41);
    chk("a_channel_c41", 32'(o_channel), 2);
    goto(d);
    chk("a_done_level", 32'(o_done), 1);
    i_start     = 1'b1;
    i_base_addr = 16'h7000;
    tick();
    i_start = 1'b0;
    chk("a_busy_after_done", 32'(o_busy), 0);
    goto(d + 3);
    chk("a_busy_ignored_start", 32'(o_busy), 0);
    chk_empty("a");

    // Stall 5 cycles mid-row, plus a start re-pulse while busy.
    start(16'h0200, s);
    expect_run(16'h0200, s, 5, 5, d);
    goto(s + 6);
    i_stall = 1'b1;
    goto(s + 8);
    chk("b_busy_restart", 32'(o_busy), 1);
    i_start     = 1'b1;
    i_base_addr = 16'h9999;
    tick();
    i_start = 1'b0;
    goto(s + 11);
    i_stall = 1'b0;
    goto(d + 1);
    chk("b_busy_end", 32'(o_busy), 0);
    chk_empty("b");

    // Reset asserted in cycle 8 of FETCH.
    start(16'h0300, s);
    expect_run(16'h0300, s, PIX, 0, d);
    goto(s + 8);
    rst = 1'b1;
    rd_q.delete();
    px_q.delete();
    cd_q.delete();
    done_q.delete();
    #1;
    chk_all_zero("midrst");
    tick();
    tick();
    rst = 1'b0;

    // Restart after reset at a base that wraps the address space.
    start(16'hFFFE, s);
    expect_run(16'hFFFE, s, PIX, 0, d);
    chk("e_wincnt_c1", 32'(o_win_count), 0);
    chk("e_channel_c1", 32'(o_channel), 0);
    chk("e_rd_addr_c1", 32'(o_rd_addr), 32'hFFFE);
    goto(d + 1);
    chk("e_busy_end", 32'(o_busy), 0);
    chk_empty("e");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
